// File: rtl/asrm_uart_bus_master_pkg.sv
// Shared command/response codes and state encodings for the serial bus master.
package asrm_uart_bus_master_pkg;

  localparam logic [7:0]  CMD_WRITE    = 8'h57;
  localparam logic [7:0]  CMD_READ     = 8'h52;
  localparam logic [7:0]  RSP_ACK      = 8'h06;
  localparam logic [7:0]  RSP_NAK      = 8'h15;
  localparam int unsigned TIMEOUT_BITS = 20;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_HOLD, S_BUS, S_RESP} state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/asrm_uart_byte_rx.sv
// 8N1 byte receiver: double-flop synchroniser, start-bit glitch reject,
// mid-bit sampling and stop-bit check.
module asrm_uart_byte_rx #(
  parameter int unsigned BIT_T = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rx_valid,
  output logic       frame_err
);
  import asrm_uart_bus_master_pkg::*;

  localparam int unsigned HALF_T = BIT_T / 2;
  localparam int unsigned CW     = $clog2(BIT_T);

  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          rx_meta, rx_sync, rx_prev;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // NOTE: every combinational output is defaulted first so no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    rx_valid  = 1'b0;
    frame_err = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_prev && !rx_sync) state_d = RX_START;
      end
      RX_START: if (cnt_q == CW'(HALF_T - 1)) begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = rx_sync ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt_q == CW'(BIT_T - 1)) begin
        cnt_d   = '0;
        shift_d = {rx_sync, shift_q[7:1]};
        bit_d   = bit_q + 1'b1;
        if (bit_q == 3'd7) state_d = RX_STOP;
      end
      RX_STOP: if (cnt_q == CW'(BIT_T - 1)) begin
        rx_valid  = rx_sync;
        frame_err = !rx_sync;
        state_d   = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign data = shift_q;

endmodule

// File: rtl/asrm_uart_bus_master.sv
// Serial-driven bus initiator: decodes W/R command frames, runs one bus cycle
// while stalling the CPU, and answers over tx. Optional macro: ASRM_UART_BUS_MASTER_TIMEOUT_EN.
module asrm_uart_bus_master #(
  parameter int unsigned wordsize       = 16,
  parameter int unsigned base_addr_size = 16,
  parameter int unsigned clk_frec       = 1000000,
  parameter int unsigned baud           = 9600
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx,
  output logic                      tx,
  output logic                      hold,
  output logic                      bus_en,
  output logic [base_addr_size-1:0] addr,
  output logic                      write_en,
  output logic [wordsize-1:0]       data_out,
  input  logic [wordsize-1:0]       data_in,
  output logic                      busy,
  output logic                      error
);
  import asrm_uart_bus_master_pkg::*;

  localparam int unsigned BIT_T = clk_frec / baud;
  localparam int unsigned CW    = $clog2(BIT_T);
  localparam int unsigned AB    = base_addr_size / 8;
  localparam int unsigned WB    = wordsize / 8;
  localparam int unsigned NMAX  = (AB > WB) ? AB : WB;
  localparam int unsigned BW    = $clog2(NMAX + 1);

  logic [7:0] rx_byte;
  logic       rx_valid, frame_err;

  asrm_uart_byte_rx #(.BIT_T(BIT_T)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data      (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  // TX shifter: tx_done marks the last cycle of a stop bit so the next byte can follow directly.
  logic          tx_busy, tx_start, tx_done;
  logic [7:0]    tx_byte;
  logic [9:0]    tx_shift;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;

  assign tx_done = tx_busy && (tx_cnt == CW'(BIT_T - 1)) && (tx_bit == 4'd9);
  assign tx      = tx_shift[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_busy  <= 1'b0;
      tx_shift <= '1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
    end else if (tx_start) begin
      tx_busy  <= 1'b1;
      tx_shift <= {1'b1, tx_byte, 1'b0};
      tx_cnt   <= '0;
      tx_bit   <= '0;
    end else if (tx_busy) begin
      if (tx_cnt == CW'(BIT_T - 1)) begin
        tx_cnt   <= '0;
        tx_shift <= {1'b1, tx_shift[9:1]};
        tx_bit   <= tx_bit + 1'b1;
        if (tx_bit == 4'd9) tx_busy <= 1'b0;
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  state_t                    state_q, state_d;
  logic [base_addr_size-1:0] addr_r, addr_d;
  logic [wordsize-1:0]       data_r, data_d, rdata_r, rdata_d;
  logic [BW-1:0]             bcnt_q, bcnt_d, resp_len;
  logic                      is_wr_q, is_wr_d, error_q, error_d;
`ifdef ASRM_UART_BUS_MASTER_TIMEOUT_EN
  localparam int unsigned TO_T = TIMEOUT_BITS * BIT_T;
  localparam int unsigned TW   = $clog2(TO_T);
  logic [TW-1:0] to_q, to_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_r  <= '0;
      data_r  <= '0;
      rdata_r <= '0;
      bcnt_q  <= '0;
      is_wr_q <= 1'b0;
      error_q <= 1'b0;
`ifdef ASRM_UART_BUS_MASTER_TIMEOUT_EN
      to_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_r  <= addr_d;
      data_r  <= data_d;
      rdata_r <= rdata_d;
      bcnt_q  <= bcnt_d;
      is_wr_q <= is_wr_d;
      error_q <= error_d;
`ifdef ASRM_UART_BUS_MASTER_TIMEOUT_EN
      to_q    <= to_d;
`endif
    end
  end

  assign resp_len = is_wr_q ? BW'(1) : BW'(WB);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_r;
    data_d   = data_r;
    rdata_d  = rdata_r;
    bcnt_d   = bcnt_q;
    is_wr_d  = is_wr_q;
    error_d  = error_q;
    tx_start = 1'b0;
    tx_byte  = RSP_NAK;
    unique case (state_q)
      S_IDLE: begin
        bcnt_d = '0;
        if (rx_valid) begin
          if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) begin
            state_d = S_ADDR;
            error_d = 1'b0;
            is_wr_d = (rx_byte == CMD_WRITE);
          end else begin
            error_d  = 1'b1;
            tx_start = !tx_busy || tx_done;
          end
        end
      end
      S_ADDR: if (rx_valid) begin
        addr_d = (addr_r << 8) | base_addr_size'(rx_byte);
        bcnt_d = bcnt_q + 1'b1;
        if (bcnt_q == BW'(AB - 1)) begin
          bcnt_d  = '0;
          state_d = is_wr_q ? S_WDATA : S_HOLD;
        end
      end
      S_WDATA: if (rx_valid) begin
        data_d = (data_r << 8) | wordsize'(rx_byte);
        bcnt_d = bcnt_q + 1'b1;
        if (bcnt_q == BW'(WB - 1)) begin
          bcnt_d  = '0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: state_d = S_BUS;
      S_BUS: begin
        if (!is_wr_q) rdata_d = data_in;
        state_d = S_RESP;
      end
      S_RESP: begin
        // Read data leaves MSB first by shifting the captured word left per byte.
        if (tx_done && bcnt_q == resp_len) begin
          state_d = S_IDLE;
        end else if ((!tx_busy || tx_done) && bcnt_q != resp_len) begin
          tx_start = 1'b1;
          tx_byte  = is_wr_q ? RSP_ACK : rdata_r[wordsize-1 -: 8];
          rdata_d  = rdata_r << 8;
          bcnt_d   = bcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Once the bus phase starts the host is quiet, so later line errors are ignored.
    if (frame_err && (state_q == S_IDLE || state_q == S_ADDR || state_q == S_WDATA)) begin
      state_d = S_IDLE;
      error_d = 1'b1;
    end

`ifdef ASRM_UART_BUS_MASTER_TIMEOUT_EN
    to_d = '0;
    if (state_q == S_ADDR || state_q == S_WDATA) begin
      if (!rx_valid) to_d = to_q + 1'b1;
      if (!rx_valid && to_q == TW'(TO_T - 1)) begin
        state_d = S_IDLE;
        error_d = 1'b1;
      end
    end
`endif
  end

  assign hold     = (state_q == S_HOLD) || (state_q == S_BUS);
  assign bus_en   = (state_q == S_BUS);
  assign write_en = bus_en && is_wr_q;
  assign busy     = (state_q != S_IDLE);
  assign addr     = addr_r;
  assign data_out = data_r;
  assign error    = error_q;

endmodule
